// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared types and constants for the div_seq divider
// Purpose: state encoding and sizing helpers used by div_seq and its bench.
// Ports: none (package).
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_DIVZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Step counter width: enough to count WIDTH restoring steps.
  function automatic int div_cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - operand/result bundle between EX stage and div_seq
// Purpose: groups the divide request, flush and result/handshake signals.
// Ports (signals):
//   start, signed_div, annul, opdata1, opdata2 : driven by EX stage (master)
//   result, ready, stall                       : driven by divider (slave)
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic               annul;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stall;

  modport master (
    output start, signed_div, annul, opdata1, opdata2,
    input  result, ready, stall
  );

  modport slave (
    input  start, signed_div, annul, opdata1, opdata2,
    output result, ready, stall
  );
endinterface

// File: rtl/div_seq_step.sv
// rtl/div_seq_step.sv - one combinational radix-2 restoring division step
// Purpose: shifts the next dividend bit into the partial remainder and
//   subtracts the divisor when it fits.
// Ports:
//   rem_i          running remainder (always < divisor_i)
//   dividend_bit_i next dividend bit, MSB first
//   divisor_i      divisor magnitude
//   rem_o          updated remainder
//   q_bit_o        quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividend_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);
  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  assign partial = {rem_i, dividend_bit_i};
  assign diff    = partial - {1'b0, divisor_i};

  // rem_i < divisor keeps partial < 2*divisor, so a non-negative difference
  // never reaches bit WIDTH and that bit is a pure borrow flag.
  assign q_bit_o = ~diff[WIDTH];
  assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
endmodule

// File: rtl/div.sv
// rtl/div.sv - radix-2 restoring divider sequencer for DIV/DIVU
// Purpose: latches operand magnitudes, produces one quotient bit per cycle,
//   stalls EX until done and returns {remainder, quotient} for HI/LO.
// Optional feature macro: DIV_EARLY_EXIT_EN (|op1| < |op2| finishes in 2 cycles).
// Ports:
//   clk     clock, rising edge
//   resetn  asynchronous active-low reset
//   div_bus slave side of div_seq_if (start/signed_div/annul/opdata1/opdata2
//           in; result/ready/stall out)
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input logic      clk,
  input logic      resetn,
  div_seq_if.slave div_bus
);
  localparam int             CW       = div_cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dq_q, dq_d;            // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               s1_q, s1_d, s2_q, s2_d; // effective operand signs
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               in_s1, in_s2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH-1:0]   step_rem, quot_shift;
  logic               step_q_bit;
  logic [WIDTH-1:0]   fin_rem_raw, fin_quot_raw, fin_rem, fin_quot;

  assign in_s1 = div_bus.signed_div & div_bus.opdata1[WIDTH-1];
  assign in_s2 = div_bus.signed_div & div_bus.opdata2[WIDTH-1];
  assign abs1  = in_s1 ? -div_bus.opdata1 : div_bus.opdata1;
  assign abs2  = in_s2 ? -div_bus.opdata2 : div_bus.opdata2;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i          (rem_q),
    .dividend_bit_i (dq_q[WIDTH-1]),
    .divisor_i      (divisor_q),
    .rem_o          (step_rem),
    .q_bit_o        (step_q_bit)
  );

  assign quot_shift = {dq_q[WIDTH-2:0], step_q_bit};

  // Final step in ON completes in the same cycle as the fix-up; DIVZERO
  // (also used for the short path) finishes from the registered values.
  assign fin_rem_raw  = (state_q == DIV_ON) ? step_rem   : rem_q;
  assign fin_quot_raw = (state_q == DIV_ON) ? quot_shift : dq_q;
  assign fin_quot     = (s1_q ^ s2_q) ? -fin_quot_raw : fin_quot_raw;
  assign fin_rem      = s1_q ? -fin_rem_raw : fin_rem_raw;

  assign div_bus.result = result_q;
  assign div_bus.ready  = ready_q;
  assign div_bus.stall  = div_bus.start & ~ready_q & ~div_bus.annul;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    if (div_bus.annul) begin
      state_d = DIV_IDLE;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          ready_d = 1'b0;
          if (div_bus.start) begin
            s1_d      = in_s1;
            s2_d      = in_s2;
            cnt_d     = '0;
            rem_d     = '0;
            divisor_d = abs2;
            if (div_bus.opdata2 == '0) begin
              state_d = DIV_DIVZERO;
              dq_d    = '0;
            end
`ifdef DIV_EARLY_EXIT_EN
            else if (abs1 < abs2) begin
              // Quotient is zero and the dividend is the remainder.
              state_d = DIV_DIVZERO;
              rem_d   = abs1;
              dq_d    = '0;
            end
`endif
            else begin
              state_d = DIV_ON;
              dq_d    = abs1;
            end
          end
        end
        DIV_DIVZERO: begin
          if (!div_bus.start) begin
            state_d = DIV_IDLE;
          end else begin
            state_d  = DIV_END;
            ready_d  = 1'b1;
            result_d = {fin_rem, fin_quot};
          end
        end
        DIV_ON: begin
          if (!div_bus.start) begin
            state_d = DIV_IDLE;
          end else begin
            rem_d = step_rem;
            dq_d  = quot_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_d  = DIV_END;
              ready_d  = 1'b1;
              result_d = {fin_rem, fin_quot};
            end
          end
        end
        DIV_END: begin
          if (!div_bus.start) begin
            state_d = DIV_IDLE;
            ready_d = 1'b0;
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      dq_q      <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dq_q      <= dq_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq
module tb_div_seq;
  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .div_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer division at 64 bits.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = sgn ? longint'(signed'(a)) : longint'(a);
    mb = sgn ? longint'(signed'(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_EXIT_EN
    if (ma < mb) return 2;
`endif
    return 33;
  endfunction

  // Called at a negedge; returns at the negedge where ready is seen (or timeout).
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output int lat, output int stl);
    lat = 0;
    stl = 0;
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      bus.opdata1    = $urandom;
      bus.opdata2    = $urandom;
      bus.signed_div = 1'($urandom);
      if (bus.ready) break;
      if (bus.stall) stl++;
    end
    res = bus.result;
  endtask

  task automatic end_op(input string name);
    bus.start = 1'b0;
    @(negedge clk);
    check(name, 64'(bus.ready), 64'd0);
  endtask

  // Start an op, then abort it by annul or by dropping start.
  task automatic abort_op(input string name, input logic use_annul);
    logic seen;
    seen = 1'b0;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd100;
    bus.opdata2    = 32'd7;
    repeat (10) @(negedge clk);
    if (use_annul) begin
      bus.annul = 1'b1;
      #1;
      check({name, "_stall"}, 64'(bus.stall), 64'd0);
      @(negedge clk);
      check({name, "_ready"}, 64'(bus.ready), 64'd0);
      bus.annul = 1'b0;
    end
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready) seen = 1'b1;
    end
    check({name, "_noready"}, 64'(seen), 64'd0);
  endtask

  vec_t        tbl[10];
  logic [63:0] res;
  int          lat, stl;
  logic        sgn;
  logic [31:0] a, b;

  initial begin
    n_vec = 0;
    n_err = 0;
    resetn         = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.annul      = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;

    tbl[0] = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},               33};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
    tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},        33};
    tbl[3] = '{1'b0, 32'd5,          32'd0,          64'd0,                         2};
    tbl[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},        33};
`ifdef DIV_EARLY_EXIT_EN
    tbl[5] = '{1'b0, 32'd3,          32'd10,         {32'd3, 32'd0},                2};
`else
    tbl[5] = '{1'b0, 32'd3,          32'd10,         {32'd3, 32'd0},                33};
`endif
    tbl[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF},        33};
    tbl[7] = '{1'b1, 32'hFFFF_FFF8,  32'd0,          64'd0,                         2};
    tbl[8] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0, 32'd1},                33};
    tbl[9] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'd3},        33};

    #1;
    check("reset_ready",  64'(bus.ready), 64'd0);
    check("reset_result", bus.result,     64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].sgn, tbl[i].a, tbl[i].b, res, lat, stl);
      check($sformatf("tbl%0d_result", i), res, tbl[i].exp_res);
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      check($sformatf("tbl%0d_stall", i), 64'(stl), 64'(tbl[i].exp_lat - 1));
      end_op($sformatf("tbl%0d_drop", i));
    end

    // Hold start after ready: result and ready stay put.
    do_op(1'b0, 32'd1000, 32'd3, res, lat, stl);
    check("hold_result", res, {32'd1, 32'd333});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_ready",  64'(bus.ready), 64'd1);
      check("hold_stable", bus.result, {32'd1, 32'd333});
    end
    end_op("hold_drop");

    abort_op("annul", 1'b1);
    do_op(1'b0, 32'd12345, 32'd100, res, lat, stl);
    check("post_annul_result",  res, {32'd45, 32'd123});
    check("post_annul_latency", 64'(lat), 64'd33);
    end_op("post_annul_drop");

    abort_op("startdrop", 1'b0);
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, res, lat, stl);
    check("post_drop_result", res, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    end_op("post_drop_drop");

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = $urandom;
        default: b = 32'hFFFF_FFFF;
      endcase
      do_op(sgn, a, b, res, lat, stl);
      check($sformatf("rand%0d_result s=%0d a=%h b=%h", i, sgn, a, b), res, ref_div(sgn, a, b));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_lat(sgn, a, b)));
      end_op($sformatf("rand%0d_drop", i));
    end

    // Asynchronous reset in the middle of an operation.
    do_op(1'b0, 32'd50, 32'd7, res, lat, stl);
    end_op("pre_reset_drop");
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd100;
    bus.opdata2    = 32'd7;
    repeat (10) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("areset_ready",  64'(bus.ready), 64'd0);
    check("areset_result", bus.result,     64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    resetn    = 1'b1;
    @(negedge clk);
    do_op(1'b0, 32'd100, 32'd7, res, lat, stl);
    check("post_reset_result",  res, {32'd2, 32'd14});
    check("post_reset_latency", 64'(lat), 64'd33);
    end_op("post_reset_drop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
